// File: rtl/rotation_cordic_if.sv
// rotation_cordic_if: start/operand and result/status bus of the rotation CORDIC
interface rotation_cordic_if #(
   parameter int DATA_WIDTH = 18
);
   logic                         rotation_cordic_enable;
   logic signed [DATA_WIDTH-1:0] input_1;
   logic signed [DATA_WIDTH-1:0] input_2;
   logic signed [DATA_WIDTH-1:0] input_angle;
   logic                         rotation_cordic_valid;
   logic                         rotation_cordic_busy;
   logic signed [DATA_WIDTH-1:0] rotation_output_1;
   logic signed [DATA_WIDTH-1:0] rotation_output_2;
   modport master (
      output rotation_cordic_enable, input_1, input_2, input_angle,
      input  rotation_cordic_valid, rotation_cordic_busy, rotation_output_1, rotation_output_2
   );
   modport slave (
      input  rotation_cordic_enable, input_1, input_2, input_angle,
      output rotation_cordic_valid, rotation_cordic_busy, rotation_output_1, rotation_output_2
   );
endinterface

// File: rtl/rotation_cordic.sv
// rotation_cordic: iterative rotation-mode CORDIC, rotates (x,y) by -angle; ROTATION_CORDIC_KN_COMP_EN enables Kn gain compensation
module rotation_cordic #(
   parameter  int NUMBER_OF_ITERATIONS = 11,
   parameter  int INT_WIDTH            = 7,
   parameter  int FRACT_WIDTH          = 11,
   localparam int DATA_WIDTH           = INT_WIDTH + FRACT_WIDTH
) (
   input logic               clk,
   input logic               rst_n,
   rotation_cordic_if.slave  bus
);
   localparam int CW = $clog2(NUMBER_OF_ITERATIONS);
   localparam logic [CW-1:0] LAST = CW'(NUMBER_OF_ITERATIONS - 1);
   localparam logic signed [DATA_WIDTH-1:0] PI      = 18'sh01921;
   localparam logic signed [DATA_WIDTH-1:0] HALF_PI = 18'sh00C91;
   localparam logic signed [DATA_WIDTH-1:0] ATAN [NUMBER_OF_ITERATIONS] = '{
      18'sh00648, 18'sh003B5, 18'sh001F5, 18'sh000FE, 18'sh0007F, 18'sh0003F,
      18'sh0001F, 18'sh0000F, 18'sh00007, 18'sh00003, 18'sh00001};
   typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
   state_t                       state_q;
   logic [CW-1:0]                count_q;
   logic                         busy_q, valid_q;
   logic signed [DATA_WIDTH-1:0] x_q, y_q, z_q, out1_q, out2_q;
   logic signed [DATA_WIDTH-1:0] x_d, y_d, z_d, x_ld, y_ld, z_ld, out1_d, out2_d;
   logic                         above, below;
   assign bus.rotation_cordic_valid = valid_q;
   assign bus.rotation_cordic_busy  = busy_q;
   assign bus.rotation_output_1     = out1_q;
   assign bus.rotation_output_2     = out2_q;
   // Load-time quadrant fold plus one micro-rotation step from the current x,y,z
   always_comb begin
      above = bus.input_angle > HALF_PI;
      below = bus.input_angle < -HALF_PI;
      x_ld  = (above || below) ? -bus.input_1 : bus.input_1;
      y_ld  = (above || below) ? -bus.input_2 : bus.input_2;
      z_ld  = above ? bus.input_angle - PI : below ? bus.input_angle + PI : bus.input_angle;
      x_d   = z_q[DATA_WIDTH-1] ? x_q - (y_q >>> count_q) : x_q + (y_q >>> count_q);
      y_d   = z_q[DATA_WIDTH-1] ? y_q + (x_q >>> count_q) : y_q - (x_q >>> count_q);
      z_d   = z_q[DATA_WIDTH-1] ? z_q + ATAN[count_q] : z_q - ATAN[count_q];
   end
`ifdef ROTATION_CORDIC_KN_COMP_EN
   localparam int PW = 2 * DATA_WIDTH;
   localparam logic signed [DATA_WIDTH-1:0] KN = 18'sh004DB;
   logic signed [PW-1:0] prod_x, prod_y;
   // Remove the CORDIC gain before the result leaves the block
   always_comb begin
      prod_x = PW'(x_q) * PW'(KN);
      prod_y = PW'(y_q) * PW'(KN);
      out1_d = DATA_WIDTH'(prod_x >>> FRACT_WIDTH);
      out2_d = DATA_WIDTH'(prod_y >>> FRACT_WIDTH);
   end
`else
   // Raw outputs; the downstream stage applies Kn
   always_comb begin
      out1_d = x_q;
      out2_d = y_q;
   end
`endif
   // Control FSM and datapath registers; a new enable always wins and restarts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         out1_q  <= '0;
         out2_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         if (bus.rotation_cordic_enable) begin
            x_q     <= x_ld;
            y_q     <= y_ld;
            z_q     <= z_ld;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ROTATE;
         end else if (state_q == ROTATE) begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
            state_q <= (count_q == LAST) ? DONE : ROTATE;
         end else if (state_q == DONE) begin
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_rotation_cordic.sv
// tb_rotation_cordic: directed checks of the rotation CORDIC in either Kn build
module tb_rotation_cordic;
   localparam int DW = 18;
`ifdef ROTATION_CORDIC_KN_COMP_EN
   localparam int ONE  = 32'sh00800;
   localparam int FIVE = 32'sh02800;
   localparam int TOL  = 8;
`else
   // Raw outputs carry the 1.6468 CORDIC gain, and so do their rounding errors
   localparam int ONE  = 32'sh00D2D;
   localparam int FIVE = 32'sh041DF;
   localparam int TOL  = 12;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   rotation_cordic_if #(.DATA_WIDTH(DW)) bus ();
   rotation_cordic dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic start(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                        input logic signed [DW-1:0] ang);
      bus.rotation_cordic_enable = 1'b1;
      bus.input_1 = a;
      bus.input_2 = b;
      bus.input_angle = ang;
      @(negedge clk);
      bus.rotation_cordic_enable = 1'b0;
   endtask
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int k = 0; k <= 40; k++) begin
         if (bus.rotation_cordic_valid === 1'b1) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask
   task automatic test_reset();
      n_tests++;
      if ({bus.rotation_cordic_valid, bus.rotation_cordic_busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_flags: valid/busy=%b expected 00", {bus.rotation_cordic_valid, bus.rotation_cordic_busy});
      end
      n_tests++;
      if ({bus.rotation_output_1, bus.rotation_output_2} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: out1=%h out2=%h expected 0", bus.rotation_output_1, bus.rotation_output_2);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_rotate();
      logic signed [DW-1:0] in1 [5] = '{18'sh00800, 18'sh00800, 18'sh01800, 18'sh00800, 18'sh00800};
      logic signed [DW-1:0] in2 [5] = '{18'sh0, 18'sh0, 18'sh02000, 18'sh0, 18'sh0};
      logic signed [DW-1:0] ang [5] = '{18'sh0, 18'sh00C91, 18'sh0076B, 18'sh01921, -18'sh00C92};
      int e1 [5] = '{ONE, 0, FIVE, -ONE, 0};
      int e2 [5] = '{0, -ONE, 0, 0, ONE};
      int lat, d1, d2;
      for (int i = 0; i < 5; i++) begin
         start(in1[i], in2[i], ang[i]);
         n_tests++;
         if (bus.rotation_cordic_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rotate%0d_busy: busy=%b expected 1", i, bus.rotation_cordic_busy);
         end
         wait_valid(lat);
         n_tests++;
         if (lat !== 12) begin
            n_fail++;
            $display("FAIL rotate%0d_latency: %0d cycles expected 12", i, lat);
         end
         d1 = int'(bus.rotation_output_1) - e1[i];
         d2 = int'(bus.rotation_output_2) - e2[i];
         n_tests++;
         if (d1 > TOL || d1 < -TOL) begin
            n_fail++;
            $display("FAIL rotate%0d_out1: got %0d expected %0d +/-%0d", i, int'(bus.rotation_output_1), e1[i], TOL);
         end
         n_tests++;
         if (d2 > TOL || d2 < -TOL) begin
            n_fail++;
            $display("FAIL rotate%0d_out2: got %0d expected %0d +/-%0d", i, int'(bus.rotation_output_2), e2[i], TOL);
         end
         n_tests++;
         if (bus.rotation_cordic_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rotate%0d_busy_end: busy=%b expected 0", i, bus.rotation_cordic_busy);
         end
         @(negedge clk);
         n_tests++;
         if (bus.rotation_cordic_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rotate%0d_valid_pulse: valid=%b expected 0", i, bus.rotation_cordic_valid);
         end
      end
   endtask
   task automatic test_abort();
      int lat, d1;
      start(18'sh01800, 18'sh02000, 18'sh0076B);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.rotation_cordic_valid, bus.rotation_cordic_busy} !== 2'b00 ||
          {bus.rotation_output_1, bus.rotation_output_2} !== '0) begin
         n_fail++;
         $display("FAIL abort_reset: valid=%b busy=%b out1=%h out2=%h expected all 0",
                  bus.rotation_cordic_valid, bus.rotation_cordic_busy, bus.rotation_output_1, bus.rotation_output_2);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start(18'sh01800, 18'sh02000, 18'sh0076B);
      repeat (3) @(negedge clk);
      start(18'sh00800, 18'sh0, 18'sh0);
      wait_valid(lat);
      n_tests++;
      if (lat !== 12) begin
         n_fail++;
         $display("FAIL abort_restart_latency: %0d cycles expected 12", lat);
      end
      d1 = int'(bus.rotation_output_1) - ONE;
      n_tests++;
      if (d1 > TOL || d1 < -TOL) begin
         n_fail++;
         $display("FAIL abort_restart_out1: got %0d expected %0d", int'(bus.rotation_output_1), ONE);
      end
      @(negedge clk);
   endtask
   task automatic test_done_restart();
      int lat, d2;
      start(18'sh00800, 18'sh0, 18'sh0);
      repeat (11) @(negedge clk);
      start(18'sh00800, 18'sh0, -18'sh00C92);
      wait_valid(lat);
      n_tests++;
      if (lat !== 12) begin
         n_fail++;
         $display("FAIL done_restart_latency: %0d cycles expected 12", lat);
      end
      d2 = int'(bus.rotation_output_2) - ONE;
      n_tests++;
      if (d2 > TOL || d2 < -TOL) begin
         n_fail++;
         $display("FAIL done_restart_out2: got %0d expected %0d", int'(bus.rotation_output_2), ONE);
      end
   endtask
   task automatic test_back_to_back();
      int lat, d1;
      start(18'sh00800, 18'sh0, 18'sh01921);
      n_tests++;
      if (bus.rotation_cordic_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_valid_at_enable: valid=%b expected 0", bus.rotation_cordic_valid);
      end
      wait_valid(lat);
      n_tests++;
      if (lat !== 12) begin
         n_fail++;
         $display("FAIL b2b_latency: %0d cycles expected 12", lat);
      end
      d1 = int'(bus.rotation_output_1) + ONE;
      n_tests++;
      if (d1 > TOL || d1 < -TOL) begin
         n_fail++;
         $display("FAIL b2b_out1: got %0d expected %0d", int'(bus.rotation_output_1), -ONE);
      end
   endtask
   initial begin
      bus.rotation_cordic_enable = 1'b0;
      bus.input_1 = '0;
      bus.input_2 = '0;
      bus.input_angle = '0;
      @(negedge clk);
      test_reset();
      test_rotate();
      test_abort();
      test_done_restart();
      test_back_to_back();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
